pipe_stage_buf: RTL and testbench
=================================

# pipe_stage_buf

Parametrised elastic pipeline stage for the in-order core, generalising the fixed-field ID/EX register into a valid/ready stage with configurable payload width, buffer depth and bubble value. It sits between any two pipeline stages (ID/EX first, then EX/MEM and MEM/WB), carrying the packed control/data bundle. It replaces global stall/flush wiring with a local handshake and keeps flush behaviour. With DEPTH ≥ 2 it acts as a skid buffer, so the upstream ready signal is fully registered.

## Interface
- WIDTH, 32, payload width in bits (1..256).
- DEPTH, 1, entries (1..8). A value of 1 gives a classic pipeline register with pass-through ready; 2..8 gives a skid buffer with registered ready.
- BUBBLE, {WIDTH{1'b0}}, value driven on out_data whenever the stage is empty (encodes a nop).
- clk  in  1  clock; all state updates on the rising edge.
- resetn  in  1  reset; synchronous, active-low.
- flush  in  1  kills all held entries and any same-cycle input.
- in_valid  in  1  upstream holds a valid payload.
- in_ready  out  1  stage accepts this cycle.
- in_data  in  WIDTH  upstream payload.
- out_valid  out  1  head entry valid.
- out_ready  in  1  downstream consumes the head this cycle (low = stall).
- out_data  out  WIDTH  head payload, or BUBBLE when empty.
- count  out  $clog2(DEPTH+1)  current occupancy.

## Operation
- Storage: DEPTH×WIDTH array, with read pointer rd_ptr, write pointer wr_ptr and an occupancy counter.
  - Pointers wrap explicitly from DEPTH-1 to 0, so non-power-of-2 depths are legal.
- Signal definitions:
  - push = in_valid & in_ready & !flush
  - pop = out_valid & out_ready & !flush
- in_ready:
  - Forced to 0 while resetn = 0.
  - DEPTH = 1: in_ready = (count == 0) | out_ready. Push and pop of a full stage in the same cycle replaces the entry.
  - DEPTH ≥ 2: in_ready = (count != DEPTH), taken from registered state only. When full, the stage refuses input even if out_ready = 1.
- count update: +1 on push only, −1 on pop only, unchanged on push and pop together.
- Data path:
  - On push, the array entry at wr_ptr is written with in_data and wr_ptr advances.
  - On pop, rd_ptr advances.
- Outputs: out_valid = (count != 0); out_data = out_valid ? mem[rd_ptr] : BUBBLE.
- Flush:
  - On a clock edge with flush = 1 (and resetn = 1): count ← 0, rd_ptr ← 0, wr_ptr ← 0.
  - This happens regardless of out_ready, in_valid, or a push/pop in the same cycle; flush wins.
  - Array contents are not cleared, but are unobservable because out_data shows BUBBLE.
- Reset (resetn = 0 at an edge):
  - Clears count and both pointers.
  - Outputs in the reset cycle and after it: out_valid = 0, out_data = BUBBLE, count = 0. in_ready = 0 while resetn is low, then follows the in_ready rules above from the first cycle resetn is high.
  - Reset mid-transfer discards all entries.
- Payload is opaque to the stage: no field decoding and no partial updates.

## Timing
- Latency: a payload accepted at edge N appears on out_data/out_valid after edge N (one cycle), for any DEPTH.
- Throughput:
  - 1 item/cycle with out_ready held high.
  - DEPTH = 1 reaches full rate through the combinational ready path.
  - DEPTH ≥ 2 sustains 1/cycle with no combinational path from out_ready to in_ready.
- Backpressure: out_data and out_valid hold stable while out_valid = 1 and out_ready = 0, except when flushed.
- A flush asserted in cycle N: out_valid = 0 from cycle N+1. A push in cycle N is lost, so upstream must re-issue.
- Order: strictly FIFO; no reordering or duplication across pointer wrap-around.
- Upstream protocol: in_valid must not depend on in_ready. out_ready may depend on out_valid.

## Test plan
- Reset: hold resetn = 0 for 3 cycles with in_valid = 1, in_data = 0xA5A5A5A5.
  - Required: in_ready = 0, out_valid = 0, out_data = BUBBLE (0x0), count = 0.
  - After release, the first accepted word appears on out_data one cycle later.
- DEPTH = 1 streaming: push 0x1..0x10 on consecutive cycles with out_ready = 1.
  - Required: out_data sequence 0x1..0x10 with no gaps; in_ready stays 1; count is 1 throughout.
- DEPTH = 3 backpressure and wrap:
  - Push 0x11, 0x22, 0x33 with out_ready = 0. Required: count = 3, in_ready = 0.
  - Then set out_ready = 1 and push 0x44, 0x55. Required: out_data order 0x11, 0x22, 0x33, 0x44, 0x55 across the pointer wrap.
- Flush collisions, DEPTH = 2, holding 0x77 and 0x88:
  - Assert flush together with push 0x99 and out_ready = 1.
  - Required: next cycle out_valid = 0, count = 0, out_data = BUBBLE; 0x99 and 0x88 never appear.
- Stall hold: with 0xDEADBEEF at the head, set out_ready = 0 for 5 cycles.
  - Required: out_data and out_valid are unchanged, and count never exceeds DEPTH.
- Reset mid-operation: with DEPTH = 4 and count = 4, assert resetn = 0 for 1 cycle.
  - Required: count = 0, out_valid = 0, and stale entries never re-emerge.

Source files
------------

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: elastic valid/ready pipeline stage with configurable
// payload width, buffer depth and bubble value. DEPTH = 1 behaves as a
// classic pipeline register with pass-through ready; DEPTH >= 2 behaves as
// a skid buffer whose upstream ready comes from registered state only.
module pipe_stage_buf #(
    parameter int              WIDTH  = 32,
    parameter int              DEPTH  = 1,
    parameter logic [WIDTH-1:0] BUBBLE = {WIDTH{1'b0}}
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    // Pointer width is kept at least one bit so DEPTH = 1 still has a
    // legal (always-zero) pointer.
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    occ;
    logic             ready_int;
    logic             has_data;
    logic             push;
    logic             pop;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            return '0;
        end
        return p + PW'(1);
    endfunction

    // Ready source: combinational through out_ready for the single-entry
    // register, purely registered occupancy for the skid buffer.
    generate
        if (DEPTH == 1) begin : g_pass_ready
            assign ready_int = (occ == '0) | out_ready;
        end else begin : g_reg_ready
            assign ready_int = (occ != CW'(DEPTH));
        end
    endgenerate

    // Outputs are masked while resetn is low so the reset cycle itself
    // already presents an empty, non-accepting stage.
    assign has_data  = (occ != '0);
    assign in_ready  = resetn & ready_int;
    assign out_valid = resetn & has_data;
    assign out_data  = out_valid ? mem[rd_ptr] : BUBBLE;
    assign count     = resetn ? occ : '0;

    assign push = in_valid & in_ready & ~flush;
    assign pop  = out_valid & out_ready & ~flush;

    // Payload storage; contents are never cleared, emptiness hides them.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // Pointer and occupancy bookkeeping; reset and flush both empty the stage.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            occ    <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else if (flush) begin
            occ    <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({push, pop})
                2'b10:   occ <= occ + CW'(1);
                2'b01:   occ <= occ - CW'(1);
                default: occ <= occ;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb_pipe_stage_buf: directed checks of pipe_stage_buf at depths 1, 2, 3, 4.
module tb_pipe_stage_buf;

    logic clk = 1'b0;
    logic resetn;
    logic flush;

    logic        d1_in_valid, d1_in_ready, d1_out_valid, d1_out_ready;
    logic [31:0] d1_in_data, d1_out_data;
    logic [0:0]  d1_count;

    logic        d2_in_valid, d2_in_ready, d2_out_valid, d2_out_ready;
    logic [31:0] d2_in_data, d2_out_data;
    logic [1:0]  d2_count;

    logic        d3_in_valid, d3_in_ready, d3_out_valid, d3_out_ready;
    logic [31:0] d3_in_data, d3_out_data;
    logic [1:0]  d3_count;

    logic        d4_in_valid, d4_in_ready, d4_out_valid, d4_out_ready;
    logic [31:0] d4_in_data, d4_out_data;
    logic [2:0]  d4_count;

    int error_count = 0;
    int check_count = 0;
    int in_idx;
    int out_idx;
    logic [31:0] exp3 [5];

    pipe_stage_buf #(.WIDTH(32), .DEPTH(1)) u_d1 (
        .clk(clk), .resetn(resetn), .flush(flush),
        .in_valid(d1_in_valid), .in_ready(d1_in_ready), .in_data(d1_in_data),
        .out_valid(d1_out_valid), .out_ready(d1_out_ready), .out_data(d1_out_data),
        .count(d1_count)
    );

    pipe_stage_buf #(.WIDTH(32), .DEPTH(2)) u_d2 (
        .clk(clk), .resetn(resetn), .flush(flush),
        .in_valid(d2_in_valid), .in_ready(d2_in_ready), .in_data(d2_in_data),
        .out_valid(d2_out_valid), .out_ready(d2_out_ready), .out_data(d2_out_data),
        .count(d2_count)
    );

    pipe_stage_buf #(.WIDTH(32), .DEPTH(3)) u_d3 (
        .clk(clk), .resetn(resetn), .flush(flush),
        .in_valid(d3_in_valid), .in_ready(d3_in_ready), .in_data(d3_in_data),
        .out_valid(d3_out_valid), .out_ready(d3_out_ready), .out_data(d3_out_data),
        .count(d3_count)
    );

    pipe_stage_buf #(.WIDTH(32), .DEPTH(4)) u_d4 (
        .clk(clk), .resetn(resetn), .flush(flush),
        .in_valid(d4_in_valid), .in_ready(d4_in_ready), .in_data(d4_in_data),
        .out_valid(d4_out_valid), .out_ready(d4_out_ready), .out_data(d4_out_data),
        .count(d4_count)
    );

    // Free-running clock, 10 time-unit period.
    always #5 clk = ~clk;

    // Hard time limit so a stuck run still ends with a report.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_count++;
        if (obs !== exp) begin
            error_count++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Directed test sequence; inputs change 1 unit after each rising edge.
    initial begin
        exp3 = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55};
        resetn = 1'b0;
        flush  = 1'b0;
        d1_in_valid = 1'b0; d1_in_data = '0; d1_out_ready = 1'b0;
        d2_in_valid = 1'b0; d2_in_data = '0; d2_out_ready = 1'b0;
        d3_in_valid = 1'b0; d3_in_data = '0; d3_out_ready = 1'b0;
        d4_in_valid = 1'b0; d4_in_data = '0; d4_out_ready = 1'b0;

        // Reset held three cycles with a valid word offered.
        d1_in_valid = 1'b1;
        d1_in_data  = 32'hA5A5A5A5;
        d4_in_valid = 1'b1;
        d4_in_data  = 32'hA5A5A5A5;
        repeat (3) tick();
        checkOutput("rst_d1_in_ready",  32'(d1_in_ready), 32'd0);
        checkOutput("rst_d1_out_valid", 32'(d1_out_valid), 32'd0);
        checkOutput("rst_d1_out_data",  d1_out_data, 32'h0);
        checkOutput("rst_d1_count",     32'(d1_count), 32'd0);
        checkOutput("rst_d4_in_ready",  32'(d4_in_ready), 32'd0);
        checkOutput("rst_d4_count",     32'(d4_count), 32'd0);

        // First accepted word after release appears one cycle later.
        resetn = 1'b1;
        d4_in_valid = 1'b0;
        d1_in_data  = 32'h00001234;
        #1;
        checkOutput("rel_d1_in_ready", 32'(d1_in_ready), 32'd1);
        tick();
        d1_in_valid = 1'b0;
        #1;
        checkOutput("rel_d1_out_valid", 32'(d1_out_valid), 32'd1);
        checkOutput("rel_d1_out_data",  d1_out_data, 32'h00001234);
        checkOutput("rel_d1_count",     32'(d1_count), 32'd1);
        checkOutput("d1_full_stalled_ready", 32'(d1_in_ready), 32'd0);
        d1_out_ready = 1'b1;
        #1;
        checkOutput("d1_full_pass_ready", 32'(d1_in_ready), 32'd1);
        tick();
        checkOutput("d1_drained_bubble", d1_out_data, 32'h0);

        // DEPTH=1 streaming at full rate.
        for (int i = 1; i <= 16; i++) begin
            d1_in_valid = 1'b1;
            d1_in_data  = 32'(i);
            #1;
            checkOutput("d1_stream_ready", 32'(d1_in_ready), 32'd1);
            tick();
            checkOutput("d1_stream_data",  d1_out_data, 32'(i));
            checkOutput("d1_stream_valid", 32'(d1_out_valid), 32'd1);
            checkOutput("d1_stream_count", 32'(d1_count), 32'd1);
        end
        d1_in_valid = 1'b0;
        tick();
        checkOutput("d1_stream_end_valid", 32'(d1_out_valid), 32'd0);

        // DEPTH=3 fill under backpressure, then drain across the wrap.
        d3_out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            d3_in_valid = 1'b1;
            d3_in_data  = exp3[i];
            tick();
        end
        d3_in_valid = 1'b0;
        #1;
        checkOutput("d3_full_count", 32'(d3_count), 32'd3);
        checkOutput("d3_full_ready", 32'(d3_in_ready), 32'd0);
        checkOutput("d3_full_head",  d3_out_data, 32'h11);
        d3_out_ready = 1'b1;
        #1;
        checkOutput("d3_full_ready_or", 32'(d3_in_ready), 32'd0);
        in_idx  = 3;
        out_idx = 0;
        for (int cyc = 0; cyc < 20 && out_idx < 5; cyc++) begin
            d3_in_valid = (in_idx < 5);
            d3_in_data  = (in_idx < 5) ? exp3[in_idx] : 32'h0;
            #1;
            if (d3_out_valid) begin
                checkOutput("d3_order", d3_out_data, exp3[out_idx]);
                out_idx++;
            end
            if (d3_in_valid && d3_in_ready) begin
                in_idx++;
            end
            tick();
        end
        d3_in_valid = 1'b0;
        #1;
        checkOutput("d3_drained_all", 32'(out_idx), 32'd5);
        checkOutput("d3_drained_valid", 32'(d3_out_valid), 32'd0);

        // DEPTH=2 flush colliding with push and pop.
        d2_out_ready = 1'b0;
        d2_in_valid  = 1'b1;
        d2_in_data   = 32'h77;
        tick();
        d2_in_data   = 32'h88;
        tick();
        d2_in_valid  = 1'b0;
        #1;
        checkOutput("d2_full_count", 32'(d2_count), 32'd2);
        checkOutput("d2_full_ready", 32'(d2_in_ready), 32'd0);
        checkOutput("d2_full_head",  d2_out_data, 32'h77);
        flush        = 1'b1;
        d2_in_valid  = 1'b1;
        d2_in_data   = 32'h99;
        d2_out_ready = 1'b1;
        tick();
        flush       = 1'b0;
        d2_in_valid = 1'b0;
        #1;
        checkOutput("flush_valid", 32'(d2_out_valid), 32'd0);
        checkOutput("flush_count", 32'(d2_count), 32'd0);
        checkOutput("flush_data",  d2_out_data, 32'h0);
        checkOutput("flush_ready", 32'(d2_in_ready), 32'd1);
        repeat (3) begin
            tick();
            checkOutput("flush_stays_empty", 32'(d2_out_valid), 32'd0);
        end
        d2_in_valid = 1'b1;
        d2_in_data  = 32'hAB;
        tick();
        d2_in_valid = 1'b0;
        #1;
        checkOutput("post_flush_data",  d2_out_data, 32'hAB);
        checkOutput("post_flush_count", 32'(d2_count), 32'd1);
        tick();
        checkOutput("post_flush_drain", 32'(d2_count), 32'd0);

        // Stall hold: head stays put while downstream is stalled.
        d2_out_ready = 1'b0;
        d2_in_valid  = 1'b1;
        d2_in_data   = 32'hDEADBEEF;
        tick();
        d2_in_data   = 32'h00000001;
        checkOutput("stall_head_start", d2_out_data, 32'hDEADBEEF);
        for (int k = 0; k < 5; k++) begin
            tick();
            checkOutput("stall_data",  d2_out_data, 32'hDEADBEEF);
            checkOutput("stall_valid", 32'(d2_out_valid), 32'd1);
            checkOutput("stall_count_bound", 32'(d2_count <= 2'd2), 32'd1);
        end
        checkOutput("stall_count_full", 32'(d2_count), 32'd2);
        d2_in_valid  = 1'b0;
        d2_out_ready = 1'b1;
        tick();
        checkOutput("stall_second_word", d2_out_data, 32'h00000001);
        tick();
        checkOutput("stall_drained", 32'(d2_out_valid), 32'd0);

        // DEPTH=4 full, then reset for one cycle.
        d4_out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            d4_in_valid = 1'b1;
            d4_in_data  = 32'hC1 + 32'(i);
            tick();
        end
        d4_in_valid = 1'b0;
        #1;
        checkOutput("d4_full_count", 32'(d4_count), 32'd4);
        checkOutput("d4_full_ready", 32'(d4_in_ready), 32'd0);
        checkOutput("d4_full_head",  d4_out_data, 32'hC1);
        resetn = 1'b0;
        #1;
        checkOutput("d4_rst_ready", 32'(d4_in_ready), 32'd0);
        tick();
        resetn = 1'b1;
        #1;
        checkOutput("d4_rst_count", 32'(d4_count), 32'd0);
        checkOutput("d4_rst_valid", 32'(d4_out_valid), 32'd0);
        checkOutput("d4_rst_data",  d4_out_data, 32'h0);
        d4_in_valid  = 1'b1;
        d4_in_data   = 32'hE1;
        d4_out_ready = 1'b1;
        tick();
        d4_in_valid = 1'b0;
        #1;
        checkOutput("d4_after_rst_data",  d4_out_data, 32'hE1);
        checkOutput("d4_after_rst_count", 32'(d4_count), 32'd1);
        repeat (3) begin
            tick();
            checkOutput("d4_no_stale", 32'(d4_out_valid), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", error_count, check_count);
        $finish;
    end

endmodule
